// File: rtl/or_gate_core_if.sv
// or_gate_core_if: operand, result and status signals of the registered OR stage
interface or_gate_core_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cnt_clr;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             any_high;
  logic [CNT_W-1:0] hi_count;
  modport master (
    output in_valid, in1, in2, cnt_clr,
    input  out, out_valid, any_high, hi_count
  );
  modport slave (
    input  in_valid, in1, in2, cnt_clr,
    output out, out_valid, any_high, hi_count
  );
endinterface

// File: rtl/or_gate_core.sv
// or_gate_core: registered bitwise OR with valid, reduction flag and saturating non-zero counter
module or_gate_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  or_gate_core_if.slave bus
);
  logic [WIDTH-1:0] res;
  assign res = bus.in1 | bus.in2;
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.any_high  <= 1'b0;
      bus.hi_count  <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out      <= res;
        bus.any_high <= |res;
      end
      // clear beats a simultaneous increment; all-ones means saturated
      if (bus.cnt_clr)
        bus.hi_count <= '0;
      else if (bus.in_valid && |res && !(&bus.hi_count))
        bus.hi_count <= bus.hi_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_or_gate_core.sv
// tb_or_gate_core: directed checks of a 1-bit and an 8-bit/2-bit-counter instance against a model and scoreboard
module tb_or_gate_core;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;

  or_gate_core_if #(.WIDTH(1), .CNT_W(16)) ia ();
  or_gate_core_if #(.WIDTH(8), .CNT_W(2))  ib ();

  or_gate_core #(.WIDTH(1), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  or_gate_core #(.WIDTH(8), .CNT_W(2))  dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));

  logic [7:0]  exp_out [2];
  logic        exp_vld [2];
  logic        exp_any [2];
  logic [15:0] exp_cnt [2];
  logic [15:0] cmax [2] = '{16'hFFFF, 16'd3};
  logic [7:0]  mask [2] = '{8'h01, 8'hFF};
  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input int s, input logic r, input logic v,
                      input logic [7:0] a, input logic [7:0] b, input logic clr, input string tag);
    logic [7:0] res, o, sb;
    logic [15:0] c;
    logic ov, oa;
    int other;
    other = 1 - s;
    if (s == 0) begin
      rst_a = r; ia.in_valid = v; ia.in1 = a[0]; ia.in2 = b[0]; ia.cnt_clr = clr;
      rst_b = 1'b0; ib.in_valid = 1'b0; ib.cnt_clr = 1'b0;
    end else begin
      rst_b = r; ib.in_valid = v; ib.in1 = a; ib.in2 = b; ib.cnt_clr = clr;
      rst_a = 1'b0; ia.in_valid = 1'b0; ia.cnt_clr = 1'b0;
    end
    exp_vld[other] = 1'b0;
    res = (a | b) & mask[s];
    if (r) begin
      exp_out[s] = '0; exp_vld[s] = 1'b0; exp_any[s] = 1'b0; exp_cnt[s] = '0;
      if (s == 0) q0.delete(); else q1.delete();
    end else begin
      exp_vld[s] = v;
      if (v) begin
        exp_out[s] = res;
        exp_any[s] = |res;
        if (s == 0) q0.push_back(res); else q1.push_back(res);
      end
      if (clr) exp_cnt[s] = '0;
      else if (v && res != 0 && exp_cnt[s] != cmax[s]) exp_cnt[s] = exp_cnt[s] + 16'd1;
    end
    @(posedge clk);
    #1;
    o  = (s == 0) ? {7'b0, ia.out} : ib.out;
    ov = (s == 0) ? ia.out_valid : ib.out_valid;
    oa = (s == 0) ? ia.any_high : ib.any_high;
    c  = (s == 0) ? ia.hi_count : {14'b0, ib.hi_count};
    chk({tag, ".out_valid"}, {15'b0, ov}, {15'b0, exp_vld[s]});
    chk({tag, ".out"}, {8'b0, o}, {8'b0, exp_out[s]});
    chk({tag, ".any_high"}, {15'b0, oa}, {15'b0, exp_any[s]});
    chk({tag, ".hi_count"}, c, exp_cnt[s]);
    if (ov) begin
      chk({tag, ".sb_pending"}, {15'b0, (s == 0) ? q0.size() > 0 : q1.size() > 0}, 16'd1);
      if (s == 0 && q0.size() > 0) begin sb = q0.pop_front(); chk({tag, ".sb_out"}, {8'b0, o}, {8'b0, sb}); end
      if (s == 1 && q1.size() > 0) begin sb = q1.pop_front(); chk({tag, ".sb_out"}, {8'b0, o}, {8'b0, sb}); end
    end
  endtask

  initial begin
    ia.in_valid = 1'b0; ia.in1 = '0; ia.in2 = '0; ia.cnt_clr = 1'b0;
    ib.in_valid = 1'b0; ib.in1 = '0; ib.in2 = '0; ib.cnt_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_out[i] = '0; exp_vld[i] = 1'b0; exp_any[i] = 1'b0; exp_cnt[i] = '0;
    end
    @(posedge clk);
    #1;
    step(0, 1, 0, 8'h0, 8'h0, 0, "reset_a");
    step(1, 1, 0, 8'h0, 8'h0, 0, "reset_b");
    // truth table on the 1-bit instance
    step(0, 0, 1, 8'h0, 8'h0, 0, "tt00");
    step(0, 0, 1, 8'h0, 8'h1, 0, "tt01");
    step(0, 0, 1, 8'h1, 8'h0, 0, "tt10");
    step(0, 0, 1, 8'h1, 8'h1, 0, "tt11");
    chk("tt_count3", ia.hi_count, 16'd3);
    // hold across idle cycles
    step(0, 0, 1, 8'h1, 8'h0, 0, "hold_beat");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h0, 8'h0, 0, "hold_idle");
    chk("hold_out", {15'b0, ia.out}, 16'd1);
    // mid-stream reset drops the beat in the reset cycle
    step(0, 0, 1, 8'h1, 8'h1, 0, "stream1");
    step(0, 0, 1, 8'h1, 8'h1, 0, "stream2");
    step(0, 1, 1, 8'h1, 8'h1, 0, "mid_rst");
    step(0, 0, 1, 8'h1, 8'h1, 0, "resume");
    chk("resume_count", ia.hi_count, 16'd1);
    // vector operation on the 8-bit instance
    step(1, 0, 1, 8'hA0, 8'h05, 0, "vec_a5");
    step(1, 0, 1, 8'h00, 8'h00, 0, "vec_zero");
    step(1, 0, 1, 8'hFF, 8'h00, 0, "vec_ff");
    step(1, 0, 1, 8'h3C, 8'hC3, 0, "vec_mix");
    // saturation of the 2-bit counter
    step(1, 0, 0, 8'h00, 8'h00, 1, "clr_idle");
    for (int i = 0; i < 5; i++) step(1, 0, 1, 8'h01 << i, 8'h80, 0, "sat");
    chk("sat_count", {14'b0, ib.hi_count}, 16'd3);
    step(1, 0, 1, 8'h12, 8'h21, 1, "clr_vs_inc");
    step(1, 0, 1, 8'h40, 8'h00, 0, "after_clr");
    step(1, 0, 1, 8'h00, 8'h00, 0, "zero_no_cnt");
    step(1, 0, 1, 8'h00, 8'h02, 0, "next_inc");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
